// File: rtl/dctq_pkg.sv
// Shared widths and FSM state codes for the DCTQ quantization stage.
package dctq_pkg;

   localparam int COEF_W  = 12;
   localparam int QT_W    = 8;
   localparam int OUT_W   = 9;
   localparam int BLK_N   = 64;
   localparam int FRAC_SH = 12;
   localparam int IDX_W   = $clog2(BLK_N);
   localparam int PROD_W  = COEF_W + QT_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/quant_mult_pipe.sv
// Two-stage coefficient x reciprocal pipeline with a shared stall enable;
// valid and raster index ride alongside the data.
module quant_mult_pipe
   import dctq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance_i,
   input  logic              valid_i,
   input  logic [COEF_W-1:0] coef_i,
   input  logic [QT_W-1:0]   qt_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              valid_o,
   output logic [OUT_W-1:0]  q_o,
   output logic [IDX_W-1:0]  idx_o
);

   logic              s1Valid_q;
   logic [COEF_W-1:0] s1Coef_q;
   logic [QT_W-1:0]   s1Qt_q;
   logic [IDX_W-1:0]  s1Idx_q;
   logic              s2Valid_q;
   logic [OUT_W-1:0]  s2Q_q;
   logic [IDX_W-1:0]  s2Idx_q;
   logic signed [PROD_W-1:0] prod_d;
   logic              unusedFracBits;

   // Reciprocal is unsigned, so it gets a zero sign bit before the signed multiply.
   assign prod_d = $signed(s1Coef_q) * $signed({1'b0, s1Qt_q});
   assign unusedFracBits = ^prod_d[FRAC_SH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Coef_q  <= '0;
         s1Qt_q    <= '0;
         s1Idx_q   <= '0;
         s2Valid_q <= 1'b0;
         s2Q_q     <= '0;
         s2Idx_q   <= '0;
      end else if (advance_i) begin
         s1Valid_q <= valid_i;
         s1Coef_q  <= coef_i;
         s1Qt_q    <= qt_i;
         s1Idx_q   <= idx_i;
         s2Valid_q <= s1Valid_q;
         s2Q_q     <= prod_d[FRAC_SH +: OUT_W];
         s2Idx_q   <= s1Idx_q;
      end
   end

   assign valid_o = s2Valid_q;
   assign q_o     = s2Q_q;
   assign idx_o   = s2Idx_q;

endmodule

// File: rtl/dctq_quant_ctrl.sv
// Quantization sequencer: block FSM, coefficient index, reciprocal table
// and output framing around the multiply pipeline.
module dctq_quant_ctrl
   import dctq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COEF_W-1:0] in_coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_q,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_idx,
   input  logic              qt_we,
   input  logic [IDX_W-1:0]  qt_addr,
   input  logic [QT_W-1:0]   qt_data
);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic [QT_W-1:0]  qtMem [BLK_N];
   logic             advance;
   logic             inAccept;
   logic             outAccept;

   assign advance   = ~out_valid | out_ready;
   assign in_ready  = (state_q == ST_RUN) & advance;
   assign inAccept  = in_valid & in_ready;
   assign outAccept = out_valid & out_ready;

   // Table is not reset; updates are only taken while no block is in flight.
   always_ff @(posedge clk) begin
      if (qt_we && (state_q == ST_IDLE)) begin
         qtMem[qt_addr] <= qt_data;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            if (inAccept) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(BLK_N - 1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (outAccept && out_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   quant_mult_pipe u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance),
      .valid_i   (inAccept),
      .coef_i    (in_coef),
      .qt_i      (qtMem[idx_q]),
      .idx_i     (idx_q),
      .valid_o   (out_valid),
      .q_o       (out_q),
      .idx_o     (out_idx)
   );

   assign out_last = out_valid & (out_idx == IDX_W'(BLK_N - 1));
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_dctq_quant_ctrl.sv
// Directed block sequences with random coefficients/tables, checked against
// an arithmetic model of quantization, framing and handshake rules.
module tb_dctq_quant_ctrl;

   typedef struct {
      logic [8:0] q;
      int         idx;
      int         cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_coef;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_q;
   logic        out_last;
   logic [5:0]  out_idx;
   logic        qt_we;
   logic [5:0]  qt_addr;
   logic [7:0]  qt_data;

   int          total;
   int          bad;
   int          cycleNo;
   int          modelIdx;
   int          acceptCount;
   int          outCount;
   bit          modelBusy;
   bit          modelRun;
   bit          expectDone;
   bit          holdValid;
   bit          checkLat;
   bit          recBoundary;
   logic [8:0]  heldQ;
   logic [5:0]  heldIdx;
   logic        heldLast;
   exp_t        expQ[$];
   logic [8:0]  obsB[4];
   int          tbQt[64];
   logic [11:0] coefs[64];

   dctq_quant_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coef   (in_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .qt_we     (qt_we),
      .qt_addr   (qt_addr),
      .qt_data   (qt_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quantized value is floor(coef * recip / 4096), kept to 9 bits.
   function automatic logic [8:0] refQuant(input int c, input int q);
      int p;
      p = c * q;
      return 9'(p >>> 12);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock: observe at the falling edge, update the model, return just after the rising edge.
   task automatic tick();
      bit   busyNow;
      exp_t e;
      @(negedge clk);
      cycleNo++;
      busyNow = modelBusy;
      check("busy", 32'(busy), 32'(modelBusy));
      check("done", 32'(done), 32'(expectDone));
      expectDone = 1'b0;
      if (holdValid) begin
         check("holdValid", 32'(out_valid), 32'd1);
         check("holdQ", 32'(out_q), 32'(heldQ));
         check("holdIdx", 32'(out_idx), 32'(heldIdx));
         check("holdLast", 32'(out_last), 32'(heldLast));
      end
      if (out_valid && !out_ready) check("inReadyStall", 32'(in_ready), 32'd0);
      if (!modelRun) check("inReadyClosed", 32'(in_ready), 32'd0);
      if (out_valid && expQ.size() == 0) begin
         check("spuriousOut", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
         e = expQ[0];
         check("outQ", 32'(out_q), 32'(e.q));
         check("outIdx", 32'(out_idx), 32'(e.idx[5:0]));
         check("outLast", 32'(out_last), 32'(e.idx == 63));
         if (out_ready) begin
            if (checkLat) check("latency", 32'(cycleNo - e.cyc), 32'd2);
            if (recBoundary && e.idx < 4) obsB[e.idx] = out_q;
            void'(expQ.pop_front());
            outCount++;
            if (e.idx == 63) begin
               expectDone = 1'b1;
               modelBusy  = 1'b0;
            end
         end
      end else begin
         check("lastWithoutValid", 32'(out_last), 32'd0);
      end
      holdValid = out_valid && !out_ready;
      heldQ     = out_q;
      heldIdx   = out_idx;
      heldLast  = out_last;
      if (in_valid && in_ready) begin
         e.q   = refQuant(int'($signed(in_coef)), tbQt[modelIdx % 64]);
         e.idx = modelIdx;
         e.cyc = cycleNo;
         expQ.push_back(e);
         modelIdx++;
         acceptCount++;
         if (modelIdx == 64) modelRun = 1'b0;
      end
      if (qt_we && !busyNow) tbQt[qt_addr] = int'(qt_data);
      if (start && !busyNow) begin
         modelBusy = 1'b1;
         modelRun  = 1'b1;
         modelIdx  = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic writeQt(input int addr, input int data);
      qt_we   = 1'b1;
      qt_addr = 6'(addr);
      qt_data = 8'(data);
      tick();
      qt_we   = 1'b0;
   endtask

   task automatic randomCoefs();
      for (int i = 0; i < 64; i++) coefs[i] = 12'($urandom);
      coefs[5] = 12'd1500;
   endtask

   // Runs one block; limit < 64 stops right after that many accepts.
   task automatic runBlock(input int limit, input int readyMode, input int validMode, input int abuseAt);
      int n;
      outCount    = 0;
      acceptCount = 0;
      start       = 1'b1;
      tick();
      start = 1'b0;
      n     = 0;
      while (((limit == 64) ? (outCount < 64) : (acceptCount < limit)) && n < 3000) begin
         in_valid  = (acceptCount < limit || limit == 64) && (validMode == 0 || n % 3 == 0);
         in_coef   = coefs[modelIdx % 64];
         out_ready = (readyMode == 0) ? 1'b1 : n[0];
         start     = (n == abuseAt);
         qt_we     = (n == abuseAt);
         qt_addr   = 6'd5;
         qt_data   = 8'd0;
         tick();
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      start     = 1'b0;
      qt_we     = 1'b0;
      if (limit == 64) begin
         check("outCount", 32'(outCount), 32'd64);
         check("acceptCount", 32'(acceptCount), 32'd64);
         tick();
         tick();
         check("idleAfter", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      total = 0; bad = 0; cycleNo = 0; modelIdx = 0; acceptCount = 0; outCount = 0;
      modelBusy = 0; modelRun = 0; expectDone = 0; holdValid = 0; checkLat = 0; recBoundary = 0;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
      qt_we = 1'b0; qt_addr = '0; qt_data = '0;
      for (int i = 0; i < 64; i++) tbQt[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rstBusy", 32'(busy), 32'd0);
      check("rstOutValid", 32'(out_valid), 32'd0);
      check("rstInReady", 32'(in_ready), 32'd0);
      check("rstOutQ", 32'(out_q), 32'd0);
      check("rstOutIdx", 32'(out_idx), 32'd0);
      rst_n = 1'b1;

      $display("[TB] block with uniform table and coefficients");
      for (int i = 0; i < 64; i++) writeQt(i, 16);
      for (int i = 0; i < 64; i++) coefs[i] = 12'd256;
      checkLat = 1'b1;
      runBlock(64, 0, 0, -1);
      checkLat = 1'b0;

      $display("[TB] arithmetic boundaries");
      writeQt(0, 255); writeQt(1, 255); writeQt(2, 1); writeQt(3, 0);
      randomCoefs();
      coefs[0] = 12'h7FF; coefs[1] = 12'h800; coefs[2] = 12'hFFF; coefs[3] = 12'd100;
      recBoundary = 1'b1;
      runBlock(64, 0, 0, -1);
      recBoundary = 1'b0;
      check("bnd2047x255", 32'(obsB[0]), 32'(9'd127));
      check("bndM2048x255", 32'(obsB[1]), 32'(9'h180));
      check("bndM1x1", 32'(obsB[2]), 32'(9'h1FF));
      check("bnd100x0", 32'(obsB[3]), 32'd0);

      $display("[TB] random table with output backpressure");
      for (int i = 0; i < 64; i++) writeQt(i, (i == 5) ? 200 : int'($urandom_range(0, 255)));
      randomCoefs();
      runBlock(64, 1, 0, -1);

      $display("[TB] start and table write while busy");
      randomCoefs();
      runBlock(64, 0, 0, 20);

      $display("[TB] input bubbles");
      randomCoefs();
      runBlock(64, 1, 1, -1);

      $display("[TB] reset mid-block");
      randomCoefs();
      runBlock(30, 0, 0, -1);
      rst_n = 1'b0;
      #1;
      check("abortOutValid", 32'(out_valid), 32'd0);
      check("abortOutQ", 32'(out_q), 32'd0);
      check("abortOutIdx", 32'(out_idx), 32'd0);
      check("abortOutLast", 32'(out_last), 32'd0);
      check("abortDone", 32'(done), 32'd0);
      check("abortBusy", 32'(busy), 32'd0);
      check("abortInReady", 32'(in_ready), 32'd0);
      expQ.delete();
      modelBusy = 0; modelRun = 0; expectDone = 0; holdValid = 0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(); tick(); tick();
      randomCoefs();
      runBlock(64, 0, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
